counter_cmd_ctrl: RTL and testbench

- Command controller for the 10000-counter datapath.
- Merges single-cycle pulses from the debounced run, clear and mode buttons with ASCII command bytes popped from the UART RX FIFO.
- Drives the counter's run enable, clear pulse and display mode.
- Optionally echoes an acknowledge byte into the UART TX FIFO.
- Sits between the button debouncers and UART FIFOs on one side and the counter core on the other.

---
 rtl/counter_cmd_pkg.sv | 35 +++
 rtl/counter_cmd_ctrl_cmd_apply.sv | 42 ++++
 rtl/counter_cmd_ctrl.sv | 137 +++++++++++++
 tb/tb_counter_cmd_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_cmd_pkg.sv
// rtl/counter_cmd_pkg.sv - shared FSM states, ASCII command bytes and byte decoder for counter_cmd_ctrl
package counter_cmd_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_POP    = 2'd1,
        S_DECODE = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_RUN  = 2'd1,
        CMD_CLR  = 2'd2,
        CMD_MODE = 2'd3
    } cmd_t;

    localparam logic [7:0] CMD_RUN_L  = 8'h72;
    localparam logic [7:0] CMD_RUN_U  = 8'h52;
    localparam logic [7:0] CMD_CLR_L  = 8'h63;
    localparam logic [7:0] CMD_CLR_U  = 8'h43;
    localparam logic [7:0] CMD_MODE_L = 8'h6D;
    localparam logic [7:0] CMD_MODE_U = 8'h4D;
    localparam logic [7:0] ACK_ERR    = 8'h3F;

    function automatic cmd_t decode_cmd(input logic [7:0] b);
        case (b)
            CMD_RUN_L,  CMD_RUN_U:  decode_cmd = CMD_RUN;
            CMD_CLR_L,  CMD_CLR_U:  decode_cmd = CMD_CLR;
            CMD_MODE_L, CMD_MODE_U: decode_cmd = CMD_MODE;
            default:                decode_cmd = CMD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/counter_cmd_ctrl_cmd_apply.sv
// rtl/counter_cmd_ctrl_cmd_apply.sv - register stage applying run toggle, clear pulse and mode wrap
module cmd_apply #(
    parameter int NUM_MODES = 2,
    parameter int MODE_W    = $clog2(NUM_MODES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_run_tgl,
    input  logic              i_clr,
    input  logic              i_mode_adv,
    output logic              o_run,
    output logic              o_clear,
    output logic [MODE_W-1:0] o_mode
);

    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

    logic              r_run;
    logic              r_clear;
    logic [MODE_W-1:0] r_mode;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_run   <= 1'b0;
            r_clear <= 1'b0;
            r_mode  <= '0;
        end else begin
            r_clear <= i_clr;
            if (i_run_tgl) begin
                r_run <= !r_run;
            end
            if (i_mode_adv) begin
                r_mode <= (r_mode == MODE_LAST) ? '0 : r_mode + 1'b1;
            end
        end
    end

    assign o_run   = r_run;
    assign o_clear = r_clear;
    assign o_mode  = r_mode;

endmodule

// File: rtl/counter_cmd_ctrl.sv
// rtl/counter_cmd_ctrl.sv - merges button pulses and UART command bytes into counter run/clear/mode control
// Optional acknowledge echo into the TX FIFO is enabled by defining CMD_ECHO_EN.
module counter_cmd_ctrl
    import counter_cmd_pkg::*;
#(
    parameter  int NUM_MODES = 2,
    localparam int MODE_W    = $clog2(NUM_MODES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_btn_run,
    input  logic              i_btn_clear,
    input  logic              i_btn_mode,
    input  logic              i_rx_empty,
    input  logic [7:0]        i_rx_data,
    output logic              o_rx_pop,
    input  logic              i_tx_full,
    output logic              o_tx_push,
    output logic [7:0]        o_tx_data,
    output logic              o_run,
    output logic              o_clear,
    output logic [MODE_W-1:0] o_mode,
    output logic              o_busy
);

    state_t r_state;
    logic   r_pend_run;
    logic   r_pend_clear;
    logic   r_pend_mode;

    logic   w_btn_run;
    logic   w_btn_clear;
    logic   w_btn_mode;
    logic   w_btn_any;
    cmd_t   w_cmd;
    logic   w_run_tgl;
    logic   w_clr;
    logic   w_mode_adv;

    assign w_btn_run   = r_pend_run   | i_btn_run;
    assign w_btn_clear = r_pend_clear | i_btn_clear;
    assign w_btn_mode  = r_pend_mode  | i_btn_mode;
    assign w_btn_any   = w_btn_run | w_btn_clear | w_btn_mode;
    assign w_cmd       = decode_cmd(i_rx_data);

    // Only S_IDLE (buttons) or S_DECODE (UART) may drive the apply stage, so one effect per edge.
    always_comb begin
        w_run_tgl  = 1'b0;
        w_clr      = 1'b0;
        w_mode_adv = 1'b0;
        if (r_state == S_IDLE) begin
            w_run_tgl  = w_btn_run;
            w_clr      = w_btn_clear;
            w_mode_adv = w_btn_mode;
        end else if (r_state == S_DECODE) begin
            w_run_tgl  = (w_cmd == CMD_RUN);
            w_clr      = (w_cmd == CMD_CLR);
            w_mode_adv = (w_cmd == CMD_MODE);
        end
    end

`ifdef CMD_ECHO_EN
    logic [7:0] r_ack_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_pend_run   <= 1'b0;
            r_pend_clear <= 1'b0;
            r_pend_mode  <= 1'b0;
`ifdef CMD_ECHO_EN
            r_ack_data   <= 8'h00;
`endif
        end else begin
            r_pend_run   <= w_btn_run;
            r_pend_clear <= w_btn_clear;
            r_pend_mode  <= w_btn_mode;
            case (r_state)
                S_IDLE: begin
                    if (w_btn_any) begin
                        r_pend_run   <= 1'b0;
                        r_pend_clear <= 1'b0;
                        r_pend_mode  <= 1'b0;
                    end else if (!i_rx_empty) begin
                        r_state <= S_POP;
                    end
                end
                S_POP: r_state <= S_DECODE;
                S_DECODE: begin
`ifdef CMD_ECHO_EN
                    r_ack_data <= (w_cmd == CMD_NONE) ? ACK_ERR : i_rx_data;
                    r_state    <= S_ACK;
`else
                    r_state    <= S_IDLE;
`endif
                end
`ifdef CMD_ECHO_EN
                S_ACK: begin
                    if (!i_tx_full) begin
                        r_state <= S_IDLE;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    cmd_apply #(
        .NUM_MODES (NUM_MODES),
        .MODE_W    (MODE_W)
    ) u_apply (
        .clk        (clk),
        .rst        (rst),
        .i_run_tgl  (w_run_tgl),
        .i_clr      (w_clr),
        .i_mode_adv (w_mode_adv),
        .o_run      (o_run),
        .o_clear    (o_clear),
        .o_mode     (o_mode)
    );

    assign o_rx_pop = (r_state == S_POP);
    assign o_busy   = (r_state != S_IDLE);

`ifdef CMD_ECHO_EN
    assign o_tx_push = (r_state == S_ACK) && !i_tx_full;
    assign o_tx_data = (r_state == S_ACK) ? r_ack_data : 8'h00;
`else
    logic w_unused_tx_full;
    assign w_unused_tx_full = i_tx_full;
    assign o_tx_push        = 1'b0;
    assign o_tx_data        = 8'h00;
`endif

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// tb/tb_counter_cmd_ctrl.sv - scoreboard bench for counter_cmd_ctrl with randomized buttons and UART bytes
module tb_counter_cmd_ctrl;

    localparam int NM = 2;
    localparam int MW = $clog2(NM);

    typedef struct {
        bit run;
        int mode;
        bit clr;
    } eff_t;

    logic          clk;
    logic          rst;
    logic          i_btn_run;
    logic          i_btn_clear;
    logic          i_btn_mode;
    logic          i_rx_empty = 1'b1;
    logic [7:0]    i_rx_data  = 8'h00;
    logic          o_rx_pop;
    logic          i_tx_full;
    logic          o_tx_push;
    logic [7:0]    o_tx_data;
    logic          o_run;
    logic          o_clear;
    logic [MW-1:0] o_mode;
    logic          o_busy;

    int         n_checks = 0;
    int         n_errs   = 0;
    eff_t       eff_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit         force_ne = 1'b0;
    bit         mon_en   = 1'b0;
    bit         m_run    = 1'b0;
    int         m_mode   = 0;
    bit         last_run = 1'b0;
    int         last_mode = 0;

    counter_cmd_ctrl #(.NUM_MODES(NM)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_btn_run   (i_btn_run),
        .i_btn_clear (i_btn_clear),
        .i_btn_mode  (i_btn_mode),
        .i_rx_empty  (i_rx_empty),
        .i_rx_data   (i_rx_data),
        .o_rx_pop    (o_rx_pop),
        .i_tx_full   (i_tx_full),
        .o_tx_push   (o_tx_push),
        .o_tx_data   (o_tx_data),
        .o_run       (o_run),
        .o_clear     (o_clear),
        .o_mode      (o_mode),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic model_effect(input bit r, input bit c, input bit m);
        eff_t e;
        if (!(r || c || m)) return;
        if (r) m_run = !m_run;
        if (m) m_mode = (m_mode + 1) % NM;
        e.run = m_run;
        e.mode = m_mode;
        e.clr = c;
        eff_q.push_back(e);
    endtask

    task automatic model_uart(input logic [7:0] b);
        bit valid;
        valid = 1'b1;
        case (b)
            8'h72, 8'h52: model_effect(1'b1, 1'b0, 1'b0);
            8'h63, 8'h43: model_effect(1'b0, 1'b1, 1'b0);
            8'h6D, 8'h4D: model_effect(1'b0, 1'b0, 1'b1);
            default:      valid = 1'b0;
        endcase
`ifdef CMD_ECHO_EN
        tx_q.push_back(valid ? b : 8'h3F);
`else
        if (valid) return;
`endif
    endtask

    // RX FIFO model plus output monitor; all sampling is mid-cycle.
    always @(negedge clk) begin
        if (o_rx_pop) begin
            n_checks++;
            if (i_rx_empty) begin
                n_errs++;
                $display("FAIL rx_pop_while_empty: got pop=1 empty=1, required pop=0");
            end
            if (rx_q.size() > 0) i_rx_data = rx_q.pop_front();
        end
        i_rx_empty = (rx_q.size() == 0) && !force_ne;

        if (mon_en && (o_clear || o_run != last_run || int'(o_mode) != last_mode)) begin
            n_checks++;
            if (eff_q.size() == 0) begin
                n_errs++;
                $display("FAIL effect_unexpected: got run=%0d mode=%0d clear=%0d, required no change",
                         o_run, o_mode, o_clear);
            end else begin
                eff_t e;
                e = eff_q.pop_front();
                if (o_run != e.run || int'(o_mode) != e.mode || o_clear != e.clr) begin
                    n_errs++;
                    $display("FAIL effect: got run=%0d mode=%0d clear=%0d, required run=%0d mode=%0d clear=%0d",
                             o_run, o_mode, o_clear, e.run, e.mode, e.clr);
                end
            end
        end
        last_run  = o_run;
        last_mode = int'(o_mode);

        if (o_tx_push) begin
            n_checks++;
            if (tx_q.size() == 0) begin
                n_errs++;
                $display("FAIL tx_unexpected: got push data=%02h, required no push", o_tx_data);
            end else begin
                logic [7:0] t;
                t = tx_q.pop_front();
                if (o_tx_data != t) begin
                    n_errs++;
                    $display("FAIL tx_data: got %02h, required %02h", o_tx_data, t);
                end
            end
        end
    end

    task automatic press(input bit r, input bit c, input bit m);
        @(posedge clk); #1;
        i_btn_run = r; i_btn_clear = c; i_btn_mode = m;
        model_effect(r, c, m);
        @(posedge clk); #1;
        i_btn_run = 1'b0; i_btn_clear = 1'b0; i_btn_mode = 1'b0;
    endtask

    task automatic uart_cmd(input logic [7:0] b, input int full_cyc);
        @(posedge clk); #1;
        rx_q.push_back(b);
        i_tx_full = (full_cyc > 0);
        model_uart(b);
        @(negedge clk);
        @(negedge clk);
        chk("rx_pop", int'(o_rx_pop), 1);
        chk("busy_pop", int'(o_busy), 1);
        @(negedge clk);
        chk("rx_pop_once", int'(o_rx_pop), 0);
        chk("busy_decode", int'(o_busy), 1);
        @(negedge clk);
`ifdef CMD_ECHO_EN
        for (int i = 0; i < full_cyc; i++) begin
            chk("ack_hold_push", int'(o_tx_push), 0);
            chk("ack_hold_busy", int'(o_busy), 1);
            @(posedge clk); #1;
            if (i == full_cyc - 1) i_tx_full = 1'b0;
            @(negedge clk);
        end
        chk("ack_push", int'(o_tx_push), 1);
        chk("busy_ack", int'(o_busy), 1);
        @(negedge clk);
`endif
        chk("busy_done", int'(o_busy), 0);
        i_tx_full = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pool [9] = '{8'h72, 8'h52, 8'h63, 8'h43, 8'h6D, 8'h4D, 8'h41, 8'h00, 8'hFF};
        logic [7:0] b;
        int         op;

        rst = 1'b0; i_btn_run = 1'b1; i_btn_clear = 1'b0; i_btn_mode = 1'b0;
        i_tx_full = 1'b0; force_ne = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_run", int'(o_run), 0);
            chk("rst_mode", int'(o_mode), 0);
            chk("rst_pop", int'(o_rx_pop), 0);
            chk("rst_busy", int'(o_busy), 0);
        end
        @(posedge clk); #1;
        rst = 1'b1; i_btn_run = 1'b0; force_ne = 1'b0;
        @(negedge clk);
        chk("rel_run", int'(o_run), 0);
        chk("rel_clear", int'(o_clear), 0);
        chk("rel_pop", int'(o_rx_pop), 0);
        chk("rel_busy", int'(o_busy), 0);
        chk("rel_push", int'(o_tx_push), 0);
        mon_en = 1'b1;

        press(1'b1, 1'b0, 1'b0);
        repeat (3) press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);

        uart_cmd(8'h72, 0);
        uart_cmd(8'h41, 5);

        // Clear button pulsed while an 'm' byte is in S_DECODE.
        @(posedge clk); #1;
        rx_q.push_back(8'h6D);
        model_uart(8'h6D);
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_btn_clear = 1'b1;
        model_effect(1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        i_btn_clear = 1'b0;
        @(negedge clk);
`ifdef CMD_ECHO_EN
        @(negedge clk);
`endif
        @(negedge clk);
        chk("collide_clear", int'(o_clear), 1);
        @(negedge clk);
        chk("collide_clear_width", int'(o_clear), 0);
        repeat (3) @(negedge clk);

        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 2);
            if (op == 0) begin
                press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                op = $urandom_range(0, 9);
                if (op == 9) b = 8'($urandom());
                else b = pool[op];
                uart_cmd(b, $urandom_range(0, 3));
            end
        end
        repeat (3) @(negedge clk);

        // Reset while the FSM is in S_POP: the popped byte is dropped without effect or ack.
        mon_en = 1'b0;
        @(posedge clk); #1;
        rx_q.push_back(8'h72);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_pop", int'(o_rx_pop), 1);
        @(negedge clk);
        chk("midrst_busy", int'(o_busy), 0);
        chk("midrst_run", int'(o_run), 0);
        chk("midrst_mode", int'(o_mode), 0);
        chk("midrst_clear", int'(o_clear), 0);
        chk("midrst_push", int'(o_tx_push), 0);
        m_run = 1'b0; m_mode = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("midrst_idle", int'(o_busy), 0);
        end
        uart_cmd(8'h52, 1);
        press(1'b1, 1'b1, 1'b1);
        repeat (4) @(negedge clk);

        chk("eff_q_drained", eff_q.size(), 0);
        chk("tx_q_drained", tx_q.size(), 0);
        chk("rx_q_drained", rx_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
